// File: rtl/pio_pkg.sv
// Shared definitions for the PIO edge-interrupt block: register word addresses
// and bus data width.
package pio_pkg;

  localparam int PIO_DW = 32;

  localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
  localparam logic [2:0] PIO_ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] PIO_ADDR_FALL_EN  = 3'd2;
  localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd3;
  localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd4;
  localparam logic [2:0] PIO_ADDR_DB_LIMIT = 3'd5;

  function automatic logic [PIO_DW-1:0] pio_zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-pin 2-flop synchroniser followed by a limit-based debounce counter.
module pio_debounce (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pin_in,
  input  logic [15:0] db_limit,
  output logic        stable
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic [15:0] r_cnt;

  // Synchronise, then commit a new level once it has disagreed for longer than
  // db_limit; the count only advances while below the limit, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= 16'd0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= 16'd0;
      end else if (r_cnt >= db_limit) begin
        r_stable <= r_sync2;
        r_cnt    <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/pio_edge_irq.sv
// Debounced pin monitor with rise/fall edge capture (write-1-to-clear) and a
// maskable level interrupt on a 3-bit-address Avalon-MM slave.
module pio_edge_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter logic [15:0] DB_RESET = 16'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  pin_in,
  output logic              irq
);

  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_fall_en;
  logic [WIDTH-1:0]  r_irq_mask;
  logic [WIDTH-1:0]  r_edge_cap;
  logic [WIDTH-1:0]  r_prev;
  logic [15:0]       r_db_limit;
  logic [PIO_DW-1:0] r_readdata;
  logic              r_irq;

  logic [WIDTH-1:0]  w_stable;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  w_cap_next;
  logic [WIDTH-1:0]  w_mask_next;
  logic [PIO_DW-1:0] w_rd_mux;
  logic              w_wr_rise;
  logic              w_wr_fall;
  logic              w_wr_mask;
  logic              w_wr_cap;
  logic              w_wr_db;
  logic              w_unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    pio_debounce u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_in   (pin_in[g]),
      .db_limit (r_db_limit),
      .stable   (w_stable[g])
    );
  end

  assign w_wr_rise = write && (address == PIO_ADDR_RISE_EN);
  assign w_wr_fall = write && (address == PIO_ADDR_FALL_EN);
  assign w_wr_mask = write && (address == PIO_ADDR_IRQ_MASK);
  assign w_wr_cap  = write && (address == PIO_ADDR_EDGE_CAP);
  assign w_wr_db   = write && (address == PIO_ADDR_DB_LIMIT);

  assign w_unused_wdata = ^writedata[31:16];

  assign w_rise      = w_stable & ~r_prev;
  assign w_fall      = ~w_stable & r_prev;
  assign w_clr       = w_wr_cap ? writedata[WIDTH-1:0] : {WIDTH{1'b0}};
  // Set terms are ORed after the clear so a coincident edge wins.
  assign w_cap_next  = (r_edge_cap & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_mask_next = w_wr_mask ? writedata[WIDTH-1:0] : r_irq_mask;

  // Read-data selection; unused upper bits and reserved words read zero.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_stable;
      PIO_ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0] = r_rise_en;
      PIO_ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0] = r_fall_en;
      PIO_ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      PIO_ADDR_EDGE_CAP: w_rd_mux[WIDTH-1:0] = r_edge_cap;
      PIO_ADDR_DB_LIMIT: w_rd_mux            = pio_zext16(r_db_limit);
      default:           w_rd_mux            = '0;
    endcase
  end

  // Control registers, edge capture, interrupt and read-data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_prev     <= '0;
      r_db_limit <= DB_RESET;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_rise) r_rise_en  <= writedata[WIDTH-1:0];
      if (w_wr_fall) r_fall_en  <= writedata[WIDTH-1:0];
      if (w_wr_db)   r_db_limit <= writedata[15:0];
      r_irq_mask <= w_mask_next;
      r_edge_cap <= w_cap_next;
      r_prev     <= w_stable;
      r_irq      <= |(w_cap_next & w_mask_next);
      if (read) r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Scoreboard bench for pio_edge_irq: stimulus pushes expectations, monitors
// pop and compare read data and interrupt level.
module tb_pio_edge_irq;

  localparam int          WIDTH = 8;
  localparam logic [15:0] DBR   = 16'h0005;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic [31:0]      writedata = 32'd0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] pin_in = '0;
  logic             irq;

  int   total = 0;
  int   bad   = 0;
  exp_t rd_q[$];
  exp_t irq_q[$];
  logic rd_cap = 1'b0;

  pio_edge_irq #(.WIDTH(WIDTH), .DB_RESET(DBR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .read      (read),
    .writedata (writedata),
    .readdata  (readdata),
    .pin_in    (pin_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: a read sampled at a posedge is compared just after it.
  always @(posedge clk) begin
    rd_cap = read;
    #1;
    if (rd_cap) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
      end else begin
        exp_t e;
        e = rd_q.pop_front();
        check(e.name, readdata, e.exp);
      end
    end
  end

  // Interrupt monitor: drains pending irq expectations just after a negedge.
  always @(negedge clk) begin
    #1;
    while (irq_q.size() > 0) begin
      exp_t e;
      e = irq_q.pop_front();
      check(e.name, {31'd0, irq}, e.exp);
    end
  end

  // All tasks start and end on a negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a; read = 1'b1;
    rd_q.push_back('{n, e});
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    address = a; writedata = d; write = 1'b1; read = 1'b1;
    rd_q.push_back('{n, e});
    @(negedge clk);
    write = 1'b0; read = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string n);
    irq_q.push_back('{n, {31'd0, e}});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: reset values
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    chk_irq(1'b0, "rst_irq");
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], (a == 5) ? {16'd0, DBR} : 32'd0, $sformatf("rst_addr%0d", a));
    end

    // 2: DB_LIMIT=0 rise on pin 0, then W1C
    wr(3'd5, 32'd0);
    wr(3'd1, 32'h01);
    wr(3'd3, 32'h01);
    pin_in[0] = 1'b1;
    cyc(2);
    rd(3'd0, 32'h00, "t2_data_early");
    rd(3'd0, 32'h01, "t2_data_3cyc");
    chk_irq(1'b1, "t2_irq_set");
    rd(3'd4, 32'h01, "t2_cap_set");
    rd(3'd4, 32'h01, "t2_cap_read_no_clear");
    wr(3'd4, 32'h01);
    chk_irq(1'b0, "t2_irq_clr");
    rd(3'd4, 32'h00, "t2_cap_clr");

    // 3: DB_LIMIT=4 glitch rejection and committed fall on pin 1
    wr(3'd5, 32'd4);
    pin_in[1] = 1'b1;
    cyc(12);
    wr(3'd2, 32'hABCD_1202);
    rd(3'd2, 32'h02, "t3_fall_en_upper_ignored");
    pin_in[1] = 1'b0;
    cyc(3);
    pin_in[1] = 1'b1;
    cyc(10);
    rd(3'd0, 32'h03, "t3_glitch_data");
    rd(3'd4, 32'h00, "t3_glitch_cap");
    pin_in[1] = 1'b0;
    cyc(6);
    rd(3'd0, 32'h03, "t3_data_6cyc");
    rd(3'd0, 32'h01, "t3_data_7cyc");
    rd(3'd4, 32'h02, "t3_cap_fall");
    chk_irq(1'b0, "t3_irq_unmasked_bit");

    // 4: set and W1C on the same edge
    wr(3'd5, 32'd0);
    wr(3'd4, 32'h02);
    pin_in[0] = 1'b0;
    cyc(6);
    rd(3'd4, 32'h00, "t4_cap_pre");
    pin_in[0] = 1'b1;
    cyc(3);
    wr(3'd4, 32'h01);
    chk_irq(1'b1, "t4_irq_set_wins");
    rd(3'd4, 32'h01, "t4_cap_set_wins");
    chk_irq(1'b1, "t4_irq_holds");
    wr(3'd4, 32'h01);
    chk_irq(1'b0, "t4_irq_clr");

    // 5: masked capture, then mask enable and drop
    wr(3'd1, 32'h05);
    wr(3'd3, 32'h00);
    pin_in[2] = 1'b1;
    cyc(6);
    rd(3'd4, 32'h04, "t5_cap");
    chk_irq(1'b0, "t5_irq_masked");
    wr(3'd3, 32'h04);
    chk_irq(1'b1, "t5_irq_unmask");
    wr(3'd3, 32'h00);
    chk_irq(1'b0, "t5_irq_mask_drop");
    rdwr(3'd3, 32'h04, 32'h00, "t5_rdwr_old");
    rd(3'd3, 32'h04, "t5_rdwr_new");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h00, "t5_reserved");

    // 6: reset mid-debounce with a captured edge
    chk_irq(1'b1, "t6_irq_pre");
    wr(3'd5, 32'd10);
    pin_in[1] = 1'b1;
    cyc(4);
    rd(3'd4, 32'h04, "t6_cap_pre");
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_readdata", readdata, 32'd0);
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(12);
    rd(3'd4, 32'h00, "t6_no_spurious_cap");
    rd(3'd1, 32'h00, "t6_rise_en");
    rd(3'd3, 32'h00, "t6_mask");
    rd(3'd5, {16'd0, DBR}, "t6_db_limit");
    rd(3'd0, 32'h07, "t6_data");
    chk_irq(1'b0, "t6_irq_post");

    cyc(3);
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", rd_q.size() + irq_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_edge_irq.md
Name: pio_edge_irq

Overview:
- Input-side companion to the bidirectional PIO pin block. It consumes the raw pin levels (the pio_pin nets, or their input path when the direction is input).
- Synchronises the pins to clk, debounces them and detects rising/falling edges.
- Latches the edges into a write-1-to-clear capture register and raises a maskable level interrupt.
- Exposes all of this on the same 3-bit-address Avalon-MM slave style used by the PIO block.

Parameters:
- WIDTH, 8, number of monitored pins (1..16).
- DB_RESET, 16'd0, reset value of the debounce limit register.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset, applies to all flops
- address  input  3  Avalon-MM register word address
- write  input  1  write strobe, single-cycle
- read  input  1  read strobe, single-cycle
- writedata  input  32  write data
- readdata  output  32  registered read data
- pin_in  input  WIDTH  raw asynchronous pin levels
- irq  output  1  level interrupt, active-high

Behaviour:
- Register map, by word address:
  - 0 DATA: read-only, debounced level in bits [WIDTH-1:0].
  - 1 RISE_EN: read/write.
  - 2 FALL_EN: read/write.
  - 3 IRQ_MASK: read/write.
  - 4 EDGE_CAP: read; writing 1 to a bit clears that bit.
  - 5 DB_LIMIT: read/write, bits [15:0].
  - 6 and 7 are reserved: reads return 0, writes are ignored.
- Unused upper bits read 0 and are ignored on write.
- Reset:
  - readdata=0 and irq=0.
  - RISE_EN, FALL_EN, IRQ_MASK and EDGE_CAP are 0; DB_LIMIT=DB_RESET.
  - Sync flops, stable and prev are 0, and all debounce counters are 0.
- Write: takes effect on the clk edge where write=1. The new value is visible to logic from the next cycle.
- Read:
  - When read=1, readdata is loaded at that clk edge with the selected register (1-cycle latency).
  - readdata holds its value while read=0.
  - A read has no side effects; it does not clear EDGE_CAP.
  - Simultaneous read and write to the same address returns the old value.
- Synchroniser: 2-flop chain per pin, producing sync[i].
- Debounce, per pin:
  - cnt is 16 bits.
  - If sync==stable: cnt<=0.
  - Else if cnt>=DB_LIMIT: stable<=sync and cnt<=0.
  - Else: cnt<=cnt+1.
  - DB_LIMIT=0 means stable follows sync with 1 cycle of delay.
  - Latency from a pin change to a DATA change is 3+DB_LIMIT cycles.
  - A bounce (sync returning to stable) restarts the count.
  - Lowering DB_LIMIT below a running cnt commits on the next cycle because the compare is >=.
  - Counters never wrap.
- Edge detect:
  - prev<=stable every cycle.
  - rise=stable&~prev; fall=~stable&prev.
  - Each is single-cycle per committed level change.
- Capture:
  - EDGE_CAP[i] <= (EDGE_CAP[i] & ~clr[i]) | (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - clr = writedata when write=1 and address=4, else 0.
  - If a set and a clear hit the same cycle, set wins.
  - Enabling RISE_EN or FALL_EN does not retro-capture earlier edges.
- irq:
  - Registered: irq <= |(EDGE_CAP_next & IRQ_MASK_next), so it asserts the cycle EDGE_CAP shows the bit.
  - Deasserts the cycle after the last masked bit clears or its mask bit is dropped.
- A pin held high through reset yields a rise 4 cycles after reset release. It is captured only if RISE_EN is already set.
- reset_n asserted mid-debounce or mid-transaction: everything returns asynchronously to reset values. No pending edge survives.

Decomposition:
- Shared package pio_pkg holds:
  - Register address constants: PIO_ADDR_DATA=0, RISE_EN=1, FALL_EN=2, IRQ_MASK=3, EDGE_CAP=4, DB_LIMIT=5.
  - The data width constant 32.
- One sub-module, pio_debounce: 2-flop synchroniser, counter and stable output for a single pin, with a DB_LIMIT input.
  - Instantiated WIDTH times with a generate loop.
- Register file, edge logic and irq live in the top level.

Test Plan:
1. Reset then read every address -> all return 0; DB_LIMIT returns DB_RESET; irq=0.
2. DB_LIMIT=0, RISE_EN=0x01, IRQ_MASK=0x01; drive pin_in[0] 0->1 -> DATA[0]=1 after 3 cycles; EDGE_CAP=0x01; irq=1. Then write EDGE_CAP=0x01 -> EDGE_CAP=0, irq=0 next cycle.
3. DB_LIMIT=4, FALL_EN=0x02, pin_in[1] high and stable:
   - Pulse pin_in[1] low for 3 cycles -> DATA[1] stays 1 and no capture.
   - Hold it low for 10 cycles -> DATA[1]=0 at 7 cycles after the change; EDGE_CAP[1]=1.
4. Edge capture coincident with a W1C write to the same bit -> EDGE_CAP bit remains 1 and irq stays 1.
5. EDGE_CAP=0x04 set with IRQ_MASK=0 -> irq=0. Write IRQ_MASK=0x04 -> irq=1 the following cycle.
6. Assert reset_n low while an edge is captured and a debounce count is in progress -> readdata, irq and all registers are 0 immediately. After release no spurious capture occurs while the enables are 0.
